apb_master_n: RTL and testbench
===============================

# apb_master_n

Parametrised APB3 bridge between the RV32I core's simple data bus and `NUM_SLAVES` APB peripherals, replacing the fixed five-slave master in the MCU top. It adds the following over the fixed five-slave master:
- parameter-driven address decode;
- a one-cycle error completion for unmapped addresses;
- PREADY-timeout protection, so a hung peripheral cannot stall the core forever.

## Interface
Parameters:
- `NUM_SLAVES`, 8: number of APB slaves, 1..16.
- `BASE_ADDR`, 32'h1000_0000: address of slave 0.
- `SLOT_BITS`, 12: log2 of the per-slave window. Slave i owns `BASE_ADDR + i*2**SLOT_BITS` up to `BASE_ADDR + (i+1)*2**SLOT_BITS - 1`.
- `TIMEOUT_CYCLES`, 255: ACCESS cycles allowed before forced completion, 1..65535. Used only with `APB_TIMEOUT_EN`.

Ports:
- `PCLK` in 1: clock, rising edge.
- `PRESET` in 1: reset, asynchronous, active-high.
- `transfer` in 1: CPU request strobe, sampled in IDLE only.
- `write` in 1: 1 = write, 0 = read.
- `addr` in 32: byte address.
- `wdata` in 32: write data.
- `rdata` out 32: read data, valid while `ready` = 1.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: error flag, valid while `ready` = 1.
- `PADDR` out 32: registered address.
- `PWRITE` out 1: registered write flag.
- `PENABLE` out 1: access phase.
- `PWDATA` out 32: registered write data.
- `PSEL` out NUM_SLAVES: one-hot select.
- `PRDATA` in NUM_SLAVES*32: slave i occupies bits [32i+31:32i].
- `PREADY` in NUM_SLAVES: per-slave ready.

## Operation
- Decode:
  - `off = addr - BASE_ADDR`; `idx = off >> SLOT_BITS`.
  - The address is mapped iff `addr >= BASE_ADDR` and `idx < NUM_SLAVES`.
  - Arithmetic is 32-bit unsigned; there is no wrap past 32'hFFFF_FFFF.
- States: IDLE, SETUP, ACCESS, ERR.
- IDLE:
  - On `transfer`=1, latch `addr`, `wdata`, `write` and the decoded index into PADDR, PWDATA, PWRITE and `sel_q`.
  - Mapped address → SETUP; unmapped → ERR.
  - `transfer`=0 → stay in IDLE.
- SETUP:
  - `PSEL[sel_q]`=1, `PENABLE`=0.
  - Unconditionally → ACCESS.
- ACCESS:
  - `PSEL[sel_q]`=1, `PENABLE`=1.
  - If `PREADY[sel_q]`=1: `ready`=1, `err`=0. `rdata` = PRDATA slice `sel_q` for reads, 0 for writes. Next state IDLE.
  - Otherwise stay in ACCESS.
- ERR:
  - `ready`=1, `err`=1, `rdata`=0; no PSEL asserted.
  - → IDLE.
- PADDR, PWDATA and PWRITE hold from SETUP until the next IDLE capture. They retain their last value while idle.
- `transfer` outside IDLE is ignored; the CPU must hold its request until `ready`.
- PREADY from non-selected slaves is ignored.
- `ready`, `err` and `rdata` are combinational from state and inputs. Outside a completion cycle they are 0.

## Timing
- Reset values: state IDLE, `PSEL`=0, `PENABLE`=0, `PWRITE`=0, `PADDR`=0, `PWDATA`=0, timeout counter 0, `ready`=0, `err`=0, `rdata`=0.
- Reset asserted mid-transfer aborts immediately; no `ready` pulse is issued for the aborted transfer.
- Zero-wait mapped access: `transfer` sampled at edge T → SETUP in T..T+1 → ACCESS in T+1..T+2, with `ready` high in that ACCESS cycle. That is 2 cycles from the capture edge to the completion cycle.
- Each low-PREADY cycle in ACCESS adds one cycle.
- Unmapped access: `ready` in the cycle after capture, i.e. 1 cycle.
- Back-to-back transfers: after completion the FSM is in IDLE for at least one cycle before the next capture. Minimum period is 3 cycles mapped, 2 cycles unmapped.

## Configuration
- Macro: `APB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY low.
  - When the count reaches `TIMEOUT_CYCLES` with PREADY still low, that cycle completes with `ready`=1, `err`=1, `rdata`=0, and the FSM returns to IDLE.
  - PREADY high in the same cycle wins: normal completion, `err`=0.
- Undefined:
  - No counter; ACCESS waits indefinitely.
  - `err` is only ever raised by ERR.

## Test plan
- Read slave 2 with PREADY tied high and PRDATA[95:64]=32'hA5A5_0001; `transfer` with addr 32'h1000_2004 → PSEL=8'h04, PADDR=32'h1000_2004, `ready` 2 cycles after capture, `rdata`=32'hA5A5_0001, `err`=0.
- Write 32'h0000_00FF to 32'h1000_0000 with slave 0 PREADY low for 3 ACCESS cycles → PWDATA and PADDR stable throughout, `ready` 5 cycles after capture, `rdata`=0.
- Access unmapped 32'h1000_8000 (NUM_SLAVES=8) and 32'h0FFF_FFFC → no PSEL ever asserted, `ready`=1, `err`=1 one cycle after capture.
- With `APB_TIMEOUT_EN`, TIMEOUT_CYCLES=4, slave 1 PREADY stuck low → `ready`=1, `err`=1 in the 4th ACCESS cycle, then IDLE. PREADY rising exactly in that cycle → `err`=0.
- Assert PRESET during ACCESS → PSEL, PENABLE and `ready` go 0 immediately with no completion pulse. A transfer after release completes normally.

Source files
------------

// File: rtl/apb_master_n.sv
// apb_master_n: APB3 bridge from the core's simple data bus to NUM_SLAVES peripherals.
//
// Decodes the CPU address into one of NUM_SLAVES windows of 2**SLOT_BITS bytes starting at
// BASE_ADDR. A mapped address runs a normal SETUP/ACCESS transfer. An unmapped address
// completes with an error one cycle after capture.
//
// Optional feature macro: APB_TIMEOUT_EN. When it is defined, an ACCESS phase that sees
// PREADY low for TIMEOUT_CYCLES cycles is forced to complete with err=1.
//
// Ports:
//   PCLK, PRESET        clock (rising edge), asynchronous active-high reset
//   transfer, write     CPU request strobe (sampled in IDLE only), 1 = write
//   addr, wdata         CPU byte address and write data
//   rdata, ready, err   completion outputs, combinational, valid only while ready=1
//   PADDR, PWRITE,
//   PWDATA              registered APB address phase
//   PENABLE             access phase
//   PSEL                one-hot slave select
//   PRDATA, PREADY      per-slave read data (32 bits per slave) and ready
module apb_master_n #(
    parameter int unsigned NUM_SLAVES     = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int unsigned SLOT_BITS      = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       transfer,
    input  logic                       write,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata,
    output logic                       ready,
    output logic                       err,
    output logic [31:0]                PADDR,
    output logic                       PWRITE,
    output logic                       PENABLE,
    output logic [31:0]                PWDATA,
    output logic [NUM_SLAVES-1:0]      PSEL,
    input  logic [NUM_SLAVES*32-1:0]   PRDATA,
    input  logic [NUM_SLAVES-1:0]      PREADY
);

    localparam int unsigned SEL_W = 4;
    localparam int unsigned CNT_W = 16;

    // Elaboration-time range checks on the configuration
    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
        $error("apb_master_n: NUM_SLAVES must be 1..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_master_n: TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_nxt;
    logic [31:0]        dec_off;
    logic [31:0]        dec_idx;
    logic               dec_mapped;
    logic               pready_sel;
    logic [31:0]        prdata_sel;
    logic               timeout_hit;
    logic [NUM_SLAVES-1:0] psel_nxt;
    logic               penable_nxt;

    // Address decode; the lower-bound test keeps addresses below BASE_ADDR from wrapping into a slot
    always_comb begin
        dec_off    = addr - BASE_ADDR;
        dec_idx    = dec_off >> SLOT_BITS;
        dec_mapped = (addr >= BASE_ADDR) && (dec_idx < 32'(NUM_SLAVES));
    end

    // Route the selected slave's ready/data; other slaves are ignored
    always_comb begin
        pready_sel = 1'b0;
        prdata_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                pready_sel = PREADY[i];
                prdata_sel = PRDATA[i*32 +: 32];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt;

    // Counts low-PREADY ACCESS cycles; cleared while in SETUP, i.e. on entry to ACCESS
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            to_cnt <= '0;
        end else if (state == S_SETUP) begin
            to_cnt <= '0;
        end else if (state == S_ACCESS && !pready_sel) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    // The Nth low cycle is the one that sees count N-1; PREADY high in that cycle takes priority
    assign timeout_hit = (state == S_ACCESS) && !pready_sel &&
                         (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (transfer) begin
                    state_nxt = dec_mapped ? S_SETUP : S_ERR;
                end
            end
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (pready_sel || timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs: completion signals from the current state, next select/enable for the APB registers
    always_comb begin
        ready       = 1'b0;
        err         = 1'b0;
        rdata       = '0;
        psel_nxt    = '0;
        penable_nxt = 1'b0;
        sel_nxt     = (state == S_IDLE) ? SEL_W'(dec_idx) : sel_q;

        case (state)
            S_ACCESS: begin
                if (pready_sel) begin
                    ready = 1'b1;
                    rdata = PWRITE ? 32'h0 : prdata_sel;
                end else if (timeout_hit) begin
                    ready = 1'b1;
                    err   = 1'b1;
                end
            end
            S_ERR: begin
                ready = 1'b1;
                err   = 1'b1;
            end
            default: ;
        endcase

        if (state_nxt == S_SETUP || state_nxt == S_ACCESS) begin
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                if (sel_nxt == SEL_W'(i)) begin
                    psel_nxt[i] = 1'b1;
                end
            end
        end
        penable_nxt = (state_nxt == S_ACCESS);
    end

    // APB address-phase registers: captured in IDLE, held until the next capture
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR   <= '0;
            PWDATA  <= '0;
            PWRITE  <= 1'b0;
            sel_q   <= '0;
            PSEL    <= '0;
            PENABLE <= 1'b0;
        end else begin
            if (state == S_IDLE && transfer) begin
                PADDR  <= addr;
                PWDATA <= wdata;
                PWRITE <= write;
                sel_q  <= dec_mapped ? SEL_W'(dec_idx) : '0;
            end
            PSEL    <= psel_nxt;
            PENABLE <= penable_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_n.sv
// Testbench for apb_master_n. It runs a table of directed transfers, a reset-abort
// sequence and randomized transfers. The randomized transfers are checked against an
// address-map / latency reference model.
module tb_apb_master_n;

    localparam int          NS   = 8;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          TO   = 4;

    logic         PCLK;
    logic         PRESET;
    logic         transfer;
    logic         write;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         ready;
    logic         err;
    logic [31:0]  PADDR;
    logic         PWRITE;
    logic         PENABLE;
    logic [31:0]  PWDATA;
    logic [NS-1:0]    PSEL;
    logic [NS*32-1:0] PRDATA;
    logic [NS-1:0]    PREADY;

    int n_cmp;
    int n_fail;

    apb_master_n #(
        .NUM_SLAVES     (NS),
        .BASE_ADDR      (BASE),
        .SLOT_BITS      (12),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PWDATA   (PWDATA),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        int          waits;
        logic [31:0] rd;
        int          exp_sel;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot index by plain division, latency from the wait count
    task automatic model(input logic wr, input logic [31:0] a, input int waits,
                         input logic [31:0] rd, output int sel, output int lat,
                         output logic e, output logic [31:0] r);
        longint unsigned off;
        sel = -1;
        if (a >= BASE) begin
            off = 64'(a - BASE);
            if (off / 4096 < 64'(NS)) sel = int'(off / 4096);
        end
        if (sel < 0) begin
            lat = 1; e = 1'b1; r = 32'h0;
        end else begin
            lat = 2 + waits; e = 1'b0; r = wr ? 32'h0 : rd;
`ifdef APB_TIMEOUT_EN
            if (waits >= TO) begin
                lat = 1 + TO; e = 1'b1; r = 32'h0;
            end
`endif
        end
    endtask

    // Runs one transfer starting just after a negedge and ends after one IDLE cycle.
    // The selected slave holds PREADY low for 'waits' ACCESS cycles; other slaves toggle randomly.
    task automatic run_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input int waits, input logic [31:0] rd, input int exp_sel,
                            input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
        logic [NS-1:0] exp_psel;
        exp_psel = '0;
        if (exp_sel >= 0) exp_psel[exp_sel] = 1'b1;
        transfer = 1'b1;
        write    = wr;
        addr     = a;
        wdata    = wd;
        for (int i = 0; i < NS; i++) begin
            PRDATA[i*32 +: 32] = (i == exp_sel) ? rd : $urandom;
        end
        PREADY = NS'($urandom);
        for (int c = 1; c <= exp_lat; c++) begin
            @(posedge PCLK);
            #1;
            PREADY = NS'($urandom);
            if (exp_sel >= 0 && c >= 2) PREADY[exp_sel] = ((c - 1) > waits);
            @(negedge PCLK);
            check("ready",   32'(ready),   32'(c == exp_lat));
            check("psel",    32'(PSEL),    32'(exp_psel));
            check("penable", 32'(PENABLE), 32'(exp_sel >= 0 && c >= 2));
            check("paddr",   PADDR,  a);
            check("pwdata",  PWDATA, wd);
            check("pwrite",  32'(PWRITE), 32'(wr));
            if (c == exp_lat) begin
                check("err",   32'(err), 32'(exp_err));
                check("rdata", rdata, exp_rdata);
            end else begin
                check("err_wait",   32'(err), 32'h0);
                check("rdata_wait", rdata,    32'h0);
            end
        end
        transfer = 1'b0;
        @(posedge PCLK);
        #1;
        PREADY = NS'($urandom);
        @(negedge PCLK);
        check("idle_ready",   32'(ready),   32'h0);
        check("idle_psel",    32'(PSEL),    32'h0);
        check("idle_penable", 32'(PENABLE), 32'h0);
        check("idle_paddr",   PADDR, a);
    endtask

    initial begin
        int          sel;
        int          lat;
        logic        e;
        logic [31:0] r;
        logic [31:0] a;
        int          w;
        logic        wr;
        logic [31:0] rd;
        logic [31:0] wd;
        int          pick;

        n_cmp    = 0;
        n_fail   = 0;
        PRESET   = 1'b1;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        PRDATA   = '0;
        PREADY   = '0;

        // Directed vectors: {wr, addr, wdata, waits, slave rdata, exp sel, exp latency, exp err, exp rdata}
        vecs[0] = '{1'b0, 32'h1000_2004, 32'h0000_0000, 0, 32'hA5A5_0001,  2, 2, 1'b0, 32'hA5A5_0001};
        vecs[1] = '{1'b1, 32'h1000_0000, 32'h0000_00FF, 3, 32'hDEAD_BEEF,  0, 5, 1'b0, 32'h0000_0000};
        vecs[2] = '{1'b0, 32'h1000_8000, 32'h0000_0000, 0, 32'h1111_1111, -1, 1, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b0, 32'h0FFF_FFFC, 32'h0000_0000, 0, 32'h2222_2222, -1, 1, 1'b1, 32'h0000_0000};
        vecs[4] = '{1'b0, 32'h1000_7FFC, 32'h0000_0000, 1, 32'h3C3C_7777,  7, 3, 1'b0, 32'h3C3C_7777};
        vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_1234, 0, 32'h4444_4444, -1, 1, 1'b1, 32'h0000_0000};
`ifdef APB_TIMEOUT_EN
        vecs[6] = '{1'b0, 32'h1000_1000, 32'h0000_0000, 10, 32'h5555_AAAA, 1, 5, 1'b1, 32'h0000_0000};
        vecs[7] = '{1'b0, 32'h1000_1010, 32'h0000_0000, 3,  32'h6666_1111, 1, 5, 1'b0, 32'h6666_1111};
`else
        vecs[6] = '{1'b0, 32'h1000_1000, 32'h0000_0000, 10, 32'h5555_AAAA, 1, 12, 1'b0, 32'h5555_AAAA};
        vecs[7] = '{1'b1, 32'h1000_6FFC, 32'h0000_0009, 3,  32'h6666_1111, 6, 5,  1'b0, 32'h0000_0000};
`endif

        // Reset values, both during reset and after release with no request
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_psel",    32'(PSEL),    32'h0);
        check("rst_penable", 32'(PENABLE), 32'h0);
        check("rst_pwrite",  32'(PWRITE),  32'h0);
        check("rst_paddr",   PADDR,  32'h0);
        check("rst_pwdata",  PWDATA, 32'h0);
        check("rst_ready",   32'(ready), 32'h0);
        check("rst_err",     32'(err),   32'h0);
        check("rst_rdata",   rdata,      32'h0);
        PRESET = 1'b0;
        repeat (2) begin
            @(negedge PCLK);
            check("noreq_psel",  32'(PSEL),  32'h0);
            check("noreq_ready", 32'(ready), 32'h0);
        end

        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].waits, vecs[i].rd,
                     vecs[i].exp_sel, vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // Reset asserted in the middle of ACCESS aborts with no completion pulse
        transfer = 1'b1;
        write    = 1'b0;
        addr     = 32'h1000_3000;
        wdata    = 32'h0;
        PREADY   = '0;
        @(posedge PCLK);
        @(posedge PCLK);
        #1;
        check("abort_in_access", 32'(PENABLE), 32'h1);
        #1;
        PRESET = 1'b1;
        #1;
        check("abort_psel",    32'(PSEL),    32'h0);
        check("abort_penable", 32'(PENABLE), 32'h0);
        check("abort_ready",   32'(ready),   32'h0);
        transfer = 1'b0;
        @(negedge PCLK);
        check("abort_ready2", 32'(ready), 32'h0);
        check("abort_paddr",  PADDR, 32'h0);
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("after_abort_ready", 32'(ready), 32'h0);
        check("after_abort_psel",  32'(PSEL),  32'h0);
        run_xfer(1'b0, 32'h1000_3008, 32'h0, 1, 32'hCAFE_0303, 3, 3, 1'b0, 32'hCAFE_0303);

        // Randomized transfers against the reference model
        for (int n = 0; n < 200; n++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 7)       a = BASE + ($urandom_range(0, NS * 4096 - 1) & 32'hFFFF_FFFC);
            else if (pick == 7) a = BASE - 4 * $urandom_range(1, 64);
            else if (pick == 8) a = BASE + NS * 4096 + 4 * $urandom_range(0, 1000);
            else                a = $urandom;
            w  = int'($urandom_range(0, 6));
            wr = 1'($urandom);
            rd = $urandom;
            wd = $urandom;
            model(wr, a, w, rd, sel, lat, e, r);
            run_xfer(wr, a, wd, w, rd, sel, lat, e, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
